// File: rtl/fifo_rd_packer_pkg.sv
// fifo_rd_packer shared types and helpers.
// Holds the packer state enum, count-width and lane-offset functions.
package fifo_rd_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Width needed to hold a word count of 0..pack.
    function automatic int cnt_width(input int pack);
        return $clog2(pack + 1);
    endfunction

    // Low bit of a dsize-wide lane inside a packed beat.
    function automatic int lane_lo(input int lane, input int dsize);
        return lane * dsize;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed-beat stream bundle.
// master: environment side; slave: the packer (drives rinc and out_*).
interface fifo_rd_packer_if
    import fifo_rd_packer_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int PACK  = 4
);
    localparam int CW = cnt_width(PACK);

    logic                  rempty;
    logic [DSIZE-1:0]      rdata;
    logic                  rinc;
    logic                  flush;
    logic [DSIZE*PACK-1:0] out_data;
    logic [CW-1:0]         out_count;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output rempty, rdata, flush, out_ready,
        input  rinc, out_data, out_count, out_valid
    );

    modport slave (
        input  rempty, rdata, flush, out_ready,
        output rinc, out_data, out_count, out_valid
    );

endinterface

// File: rtl/fifo_rd_packer.sv
// Packs PACK consecutive FIFO words into one beat on a valid/ready stream.
// Ports: rclk, rrst (sync, active-high), bus (slave: FIFO pop side + beat out).
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int PACK  = 4
)
(
    input  logic            rclk,
    input  logic            rrst,
    fifo_rd_packer_if.slave bus
);

    localparam int              CW     = cnt_width(PACK);
    localparam int              BW     = DSIZE * PACK;
    localparam logic [CW-1:0]   PACK_C = CW'(PACK);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   data_q, data_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q, valid_d;
    logic            pend_q, pend_d;

    logic            rinc;
    logic [CW-1:0]   cnt_nxt;
    logic            eff_flush;

    // Pop only when a word exists; in HOLD a pop needs a same-cycle
    // transfer so the new word lands in the freshly cleared lane 0.
    always_comb begin
        rinc = 1'b0;
        if (!rrst && !bus.rempty) begin
            rinc = (state_q == FILL) || bus.out_ready;
        end
    end

    assign bus.rinc      = rinc;
    assign bus.out_data  = data_q;
    assign bus.out_count = count_q;
    assign bus.out_valid = valid_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        count_d   = count_q;
        valid_d   = valid_q;
        pend_d    = pend_q;
        cnt_nxt   = cnt_q;
        eff_flush = 1'b0;

        unique case (state_q)
            FILL: begin
                cnt_nxt   = cnt_q + CW'(rinc);
                eff_flush = bus.flush | pend_q;
                if (rinc) begin
                    data_d[lane_lo(int'(cnt_q), DSIZE) +: DSIZE] = bus.rdata;
                end
                cnt_d = cnt_nxt;
                if (cnt_nxt == PACK_C) begin
                    // A coinciding flush is absorbed by the full beat.
                    state_d = HOLD;
                    valid_d = 1'b1;
                    count_d = PACK_C;
                    pend_d  = 1'b0;
                end else if (eff_flush) begin
                    // Empty flushes are dropped, not emitted.
                    pend_d = 1'b0;
                    if (cnt_nxt != '0) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                        count_d = cnt_nxt;
                    end
                end
            end
            HOLD: begin
                if (bus.flush) begin
                    pend_d = 1'b1;
                end
                if (bus.out_ready) begin
                    state_d = FILL;
                    valid_d = 1'b0;
                    count_d = '0;
                    data_d  = '0;
                    cnt_d   = '0;
                    if (rinc) begin
                        data_d[DSIZE-1:0] = bus.rdata;
                        cnt_d             = CW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            count_q <= count_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a FIFO model and beat scoreboard.
// Expected beats are queued by stimulus and checked on each transfer.
module tb_fifo_rd_packer;

    localparam int DSIZE = 8;
    localparam int PACK  = 4;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  c;
    } beat_t;

    logic rclk;
    logic rrst;

    fifo_rd_packer_if #(.DSIZE(DSIZE), .PACK(PACK)) bus ();

    fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    logic [7:0] mem [0:63];
    int         rd_ptr;
    int         wr_ptr;
    int         pops;
    logic       fake;
    beat_t      exp_q [$];
    int         total;
    int         bad;

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    assign bus.rempty = ~fake & (rd_ptr == wr_ptr);
    assign bus.rdata  = mem[rd_ptr[5:0]];

    always @(posedge rclk) begin
        if (bus.rinc) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr[5:0]] = v;
        wr_ptr++;
    endtask

    task automatic exp_beat(input logic [31:0] d, input logic [2:0] c);
        beat_t b;
        b.d = d;
        b.c = c;
        exp_q.push_back(b);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    // Scoreboard monitor: a transfer occurs at the next posedge.
    always @(negedge rclk) begin
        if (!rrst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat act=%0h/%0d exp=none",
                         bus.out_data, bus.out_count);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                chk("beat_data", 64'(bus.out_data), 64'(b.d));
                chk("beat_count", 64'(bus.out_count), 64'(b.c));
            end
        end
    end

    initial begin
        int p0;
        int bubbles;
        total  = 0;
        bad    = 0;
        rd_ptr = 0;
        wr_ptr = 0;
        pops   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;

        // Reset with a non-empty FIFO and flush asserted.
        rrst          = 1'b1;
        fake          = 1'b1;
        bus.flush     = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge rclk);
            chk("rst_rinc", 64'(bus.rinc), 64'd0);
            chk("rst_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_data", 64'(bus.out_data), 64'd0);
            chk("rst_count", 64'(bus.out_count), 64'd0);
        end
        @(posedge rclk);
        #1;
        rrst      = 1'b0;
        fake      = 1'b0;
        bus.flush = 1'b0;
        @(negedge rclk);
        chk("rel_rinc", 64'(bus.rinc), 64'd0);
        chk("rel_valid", 64'(bus.out_valid), 64'd0);
        chk("rel_data", 64'(bus.out_data), 64'd0);
        chk("rel_count", 64'(bus.out_count), 64'd0);

        // Full beat held against out_ready=0.
        cyc(1);
        p0 = pops;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        exp_beat(32'h44332211, 3'd4);
        cyc(6);
        push(8'h01);
        @(negedge rclk);
        chk("full_pops", 64'(pops - p0), 64'd4);
        chk("full_valid", 64'(bus.out_valid), 64'd1);
        chk("full_data", 64'(bus.out_data), 64'h44332211);
        chk("full_count", 64'(bus.out_count), 64'd4);
        chk("hold_rinc", 64'(bus.rinc), 64'd0);
        cyc(2);
        @(negedge rclk);
        chk("hold_rinc2", 64'(bus.rinc), 64'd0);
        chk("hold_data", 64'(bus.out_data), 64'h44332211);

        // Streaming 0x01..0x0C with no bubbles.
        cyc(1);
        for (int i = 2; i <= 12; i++) push(8'(i));
        exp_beat(32'h04030201, 3'd4);
        exp_beat(32'h08070605, 3'd4);
        exp_beat(32'h0C0B0A09, 3'd4);
        bus.out_ready = 1'b1;
        bubbles = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge rclk);
            if (!bus.rinc) bubbles++;
        end
        chk("stream_bubbles", 64'(bubbles), 64'd0);
        cyc(4);
        chk("stream_sb_empty", 64'(exp_q.size()), 64'd0);

        // Partial flush of two words.
        bus.out_ready = 1'b0;
        push(8'hA1); push(8'hB2);
        exp_beat(32'h0000B2A1, 3'd2);
        cyc(4);
        bus.flush = 1'b1;
        cyc(1);
        bus.flush = 1'b0;
        @(negedge rclk);
        chk("part_valid", 64'(bus.out_valid), 64'd1);
        chk("part_data", 64'(bus.out_data), 64'h0000B2A1);
        chk("part_count", 64'(bus.out_count), 64'd2);
        cyc(1);
        bus.out_ready = 1'b1;
        cyc(2);

        // Flush with nothing buffered is dropped.
        bus.flush = 1'b1;
        cyc(1);
        bus.flush = 1'b0;
        @(negedge rclk);
        chk("empty_flush_valid", 64'(bus.out_valid), 64'd0);
        cyc(3);
        chk("empty_flush_pops", 64'(exp_q.size()), 64'd0);

        // Flush arriving while a full beat is held.
        bus.out_ready = 1'b0;
        push(8'h61); push(8'h62); push(8'h63); push(8'h64);
        exp_beat(32'h64636261, 3'd4);
        exp_beat(32'h00000055, 3'd1);
        cyc(6);
        bus.flush = 1'b1;
        cyc(1);
        bus.flush = 1'b0;
        push(8'h55);
        cyc(2);
        @(negedge rclk);
        chk("pend_rinc", 64'(bus.rinc), 64'd0);
        cyc(1);
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
        @(posedge rclk);
        @(negedge rclk);
        chk("pend_valid", 64'(bus.out_valid), 64'd1);
        chk("pend_data", 64'(bus.out_data), 64'h00000055);
        chk("pend_count", 64'(bus.out_count), 64'd1);
        cyc(1);
        bus.out_ready = 1'b1;
        cyc(3);

        // Flush coinciding with the completing capture.
        push(8'h91); push(8'h92); push(8'h93);
        exp_beat(32'h99939291, 3'd4);
        cyc(5);
        push(8'h99);
        bus.flush = 1'b1;
        cyc(1);
        bus.flush = 1'b0;
        @(negedge rclk);
        chk("last_valid", 64'(bus.out_valid), 64'd1);
        chk("last_count", 64'(bus.out_count), 64'd4);
        chk("last_top", 64'(bus.out_data[31:24]), 64'h99);
        cyc(6);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
